// File: rtl/axi_to_ndata_unpack.sv
// axi_to_ndata_unpack: splits each packed 64*NUM_ELEMENTS-bit AXI beat into 64/W ndata beats of
// NUM_ELEMENTS zero-extended 64-bit elements, where W is the packet's element width in bits.
module axi_to_ndata_unpack #(
    parameter int NUM_ELEMENTS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // actual_type: data carries the element width in bits (8/16/32/64, anything else = 64)
    input  logic [7:0]                   actual_type_data,
    input  logic                         actual_type_valid,
    output logic                         actual_type_ready,
    input  logic [64*NUM_ELEMENTS-1:0]   in_tdata,
    input  logic [8*NUM_ELEMENTS-1:0]    in_tkeep,
    input  logic                         in_tlast,
    input  logic                         in_tvalid,
    output logic                         in_tready,
    output logic [NUM_ELEMENTS-1:0][63:0] out_data,
    output logic [NUM_ELEMENTS-1:0]      out_keep,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready
);
    localparam int N  = NUM_ELEMENTS;
    localparam int DW = 64 * N;
    localparam int KW = 8 * N;

    typedef enum logic [1:0] {W8, W16, W32, W64} width_e;
    typedef enum logic {EMPTY, HOLD} state_e;

    state_e        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic          last_q, last_d;
    width_e        w_q, w_d;
    logic [DW-1:0] data_q, data_d;
    logic [KW-1:0] keep_q, keep_d;

    logic          hvalid;
    logic          at_end;
    logic          accept;
    width_e        in_w;
    logic [7:0]    sub_any;
    logic [2:0]    r_max;
    logic [2:0]    top_sub;
    logic [2:0]    end_idx;

    // Every candidate element for every width and sub-beat; the output lanes pick one by (w, idx).
    logic [7:0]    el8  [8][N];
    logic [15:0]   el16 [4][N];
    logic [31:0]   el32 [2][N];
    logic [63:0]   el64 [N];
    logic [N-1:0]  kp8  [8];
    logic [N-1:0]  kp16 [4];
    logic [N-1:0]  kp32 [2];
    logic [N-1:0]  kp64;
    logic [7:0]    any8;
    logic [3:0]    any16;
    logic [1:0]    any32;

    for (genvar s = 0; s < 8; s++) begin : g_sub
        for (genvar i = 0; i < N; i++) begin : g_lane
            localparam int K = s * N + i;
            assign el8[s][i] = data_q[8*K +: 8];
            assign kp8[s][i] = keep_q[K];
            if (s < 4) begin : g_w16
                assign el16[s][i] = data_q[16*K +: 16];
                assign kp16[s][i] = keep_q[2*K];
            end
            if (s < 2) begin : g_w32
                assign el32[s][i] = data_q[32*K +: 32];
                assign kp32[s][i] = keep_q[4*K];
            end
            if (s == 0) begin : g_w64
                assign el64[i] = data_q[64*K +: 64];
                assign kp64[i] = keep_q[8*K];
            end
        end
        assign any8[s] = |kp8[s];
        if (s < 4) begin : g_any16
            assign any16[s] = |kp16[s];
        end
        if (s < 2) begin : g_any32
            assign any32[s] = |kp32[s];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_out
        assign out_data[i] = (w_q == W8)  ? {56'd0, el8[idx_q][i]}        :
                             (w_q == W16) ? {48'd0, el16[idx_q[1:0]][i]}  :
                             (w_q == W32) ? {32'd0, el32[idx_q[0]][i]}    :
                                            el64[i];
        assign out_keep[i] = (w_q == W8)  ? kp8[idx_q][i]       :
                             (w_q == W16) ? kp16[idx_q[1:0]][i] :
                             (w_q == W32) ? kp32[idx_q[0]][i]   :
                                            kp64[i];
    end

    always_comb begin
        unique case (actual_type_data)
            8'd8:    in_w = W8;
            8'd16:   in_w = W16;
            8'd32:   in_w = W32;
            default: in_w = W64;
        endcase
    end

    // Last sub-beat of the held beat: R-1 normally, highest non-empty sub-beat on a last beat.
    always_comb begin
        sub_any = 8'd0;
        r_max   = 3'd0;
        case (w_q)
            W8:      begin sub_any = any8;              r_max = 3'd7; end
            W16:     begin sub_any = {4'd0, any16};     r_max = 3'd3; end
            W32:     begin sub_any = {6'd0, any32};     r_max = 3'd1; end
            default: begin sub_any = {7'd0, |kp64};     r_max = 3'd0; end
        endcase
        top_sub = 3'd0;
        if (sub_any[1]) top_sub = 3'd1;
        if (sub_any[2]) top_sub = 3'd2;
        if (sub_any[3]) top_sub = 3'd3;
        if (sub_any[4]) top_sub = 3'd4;
        if (sub_any[5]) top_sub = 3'd5;
        if (sub_any[6]) top_sub = 3'd6;
        if (sub_any[7]) top_sub = 3'd7;
        end_idx = last_q ? top_sub : r_max;
    end

    assign hvalid            = (state_q == HOLD);
    assign at_end            = (idx_q == end_idx);
    assign out_valid         = hvalid;
    assign out_last          = hvalid && last_q && at_end;
    assign actual_type_ready = hvalid && out_ready && out_last;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        w_d       = w_q;
        data_d    = data_q;
        keep_d    = keep_q;
        in_tready = actual_type_valid && (!hvalid || (out_ready && at_end));
        accept    = in_tvalid && in_tready;

        if (hvalid && out_ready) begin
            if (at_end) begin
                idx_d   = 3'd0;
                state_d = EMPTY;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end

        // A new beat can land in the same cycle the previous one retires: no bubble.
        if (accept) begin
            state_d = HOLD;
            idx_d   = 3'd0;
            last_d  = in_tlast;
            w_d     = in_w;
            data_d  = in_tdata;
            keep_d  = in_tkeep;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            idx_q   <= 3'd0;
            last_q  <= 1'b0;
            w_q     <= W64;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            w_q     <= w_d;
        end
    end

    // NOTE: the payload needs no reset; it is only observed while hvalid, which is reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        keep_q <= keep_d;
    end

endmodule

// File: tb/tb_axi_to_ndata_unpack.sv
// Directed and scoreboarded bench for axi_to_ndata_unpack with NUM_ELEMENTS=4 (256-bit AXI).
module tb_axi_to_ndata_unpack;
    localparam int N = 4;

    typedef struct packed {
        logic [255:0] data;
        logic [3:0]   keep;
        logic         last;
    } nbeat_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         actual_type_data;
    logic               actual_type_valid;
    logic               actual_type_ready;
    logic [255:0]       in_tdata;
    logic [31:0]        in_tkeep;
    logic               in_tlast;
    logic               in_tvalid;
    logic               in_tready;
    logic [N-1:0][63:0] out_data;
    logic [N-1:0]       out_keep;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;

    int tests = 0;
    int failures = 0;
    int type_hs = 0;
    int stab_err = 0;
    int timeouts = 0;
    logic rand_ready = 1'b0;
    logic collect = 1'b0;
    nbeat_t exp_q[$];
    nbeat_t got_q[$];

    axi_to_ndata_unpack #(.NUM_ELEMENTS(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .actual_type_data(actual_type_data), .actual_type_valid(actual_type_valid),
        .actual_type_ready(actual_type_ready),
        .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitors sample on the falling edge, halfway between active edges.
    logic         prev_stall = 1'b0;
    logic [255:0] prev_data;
    logic [3:0]   prev_keep;
    logic         prev_last;
    always @(negedge clk) begin
        if (prev_stall && rst_n &&
            (!out_valid || out_data !== prev_data || out_keep !== prev_keep || out_last !== prev_last))
            stab_err++;
        prev_stall = rst_n && out_valid && !out_ready;
        prev_data  = out_data;
        prev_keep  = out_keep;
        prev_last  = out_last;
        if (actual_type_valid && actual_type_ready) type_hs++;
        if (collect && out_valid && out_ready) got_q.push_back({out_data, out_keep, out_last});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 just after the beat was taken.
    task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
        int n = 0;
        in_tdata = d; in_tkeep = k; in_tlast = l; in_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_tready) break;
            n++;
            if (n > 200) begin timeouts++; break; end
        end
        @(posedge clk); #1;
    endtask

    // Reference unpacking of one AXI beat into the expected ndata beats.
    task automatic model_beat(input logic [255:0] d, input logic [31:0] k, input logic l, input int w);
        int     r = 64 / w;
        int     reff;
        logic [7:0]  any = 8'd0;
        logic [63:0] mask;
        logic [63:0] val;
        nbeat_t nb;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        for (int s = 0; s < r; s++)
            for (int i = 0; i < N; i++)
                if (((k >> ((s * N + i) * w / 8)) & 32'd1) != 0) any = any | (8'd1 << s);
        reff = r;
        if (l) begin
            reff = 1;
            for (int s = 0; s < r; s++) if (((any >> s) & 8'd1) != 0) reff = s + 1;
        end
        for (int s = 0; s < reff; s++) begin
            nb = '0;
            for (int i = 0; i < N; i++) begin
                val = 64'(d >> (w * (s * N + i))) & mask;
                nb.data = nb.data | (256'(val) << (64 * i));
                if (((k >> ((s * N + i) * w / 8)) & 32'd1) != 0) nb.keep = nb.keep | (4'd1 << i);
            end
            nb.last = l && (s == reff - 1);
            exp_q.push_back(nb);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; actual_type_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({out_valid, out_last, actual_type_ready, in_tready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state: v/l/tr/in_rdy=%b required 0000",
                     {out_valid, out_last, actual_type_ready, in_tready});
        end
        rst_n = 1'b1;
        actual_type_valid = 1'b1;
        @(negedge clk);
        tests++;
        if ({in_tready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_tready_follows: tready/valid=%b required 10", {in_tready, out_valid});
        end
        actual_type_valid = 1'b0;
        #1;
        tests++;
        if (in_tready !== 1'b0) begin
            failures++;
            $display("FAIL reset_tready_no_type: tready=%b required 0", in_tready);
        end
        actual_type_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_w64_packet();
        logic [255:0] d [3];
        int hs0 = type_hs;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < N; i++) d[b][64*i +: 64] = {32'hB0B0_0000 + 32'(b), 32'(i)};
        actual_type_data = 8'd64;
        in_tdata = d[0]; in_tkeep = '1; in_tlast = 1'b0; in_tvalid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
            if (b < 2) begin in_tdata = d[b+1]; in_tlast = (b + 1 == 2); end
            else in_tvalid = 1'b0;
            @(negedge clk);
            tests++;
            if ({out_valid, out_data, out_keep, out_last} !== {1'b1, d[b], 4'hF, (b == 2)}) begin
                failures++;
                $display("FAIL w64_beat%0d: v=%b data=%h keep=%h last=%b required v=1 data=%h keep=f last=%b",
                         b, out_valid, out_data, out_keep, out_last, d[b], (b == 2));
            end
        end
        @(posedge clk); #1;
        tests++;
        if ({out_valid, 32'(type_hs - hs0)} !== {1'b0, 32'd1}) begin
            failures++;
            $display("FAIL w64_end: valid=%b type_handshakes=%0d required valid=0 handshakes=1",
                     out_valid, type_hs - hs0);
        end
    endtask

    task automatic test_w32_split();
        logic [255:0] d;
        for (int j = 0; j < 8; j++) d[32*j +: 32] = 32'(j);
        actual_type_data = 8'd32;
        in_tdata = d; in_tkeep = '1; in_tlast = 1'b1; in_tvalid = 1'b1;
        @(posedge clk); #1;
        in_tvalid = 1'b0;
        @(negedge clk);
        tests++;
        if ({out_valid, out_data, out_keep, out_last, in_tready} !==
            {1'b1, 64'd3, 64'd2, 64'd1, 64'd0, 4'hF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL w32_sub0: v=%b data=%h keep=%h last=%b tready=%b required v=1 data=3,2,1,0 keep=f last=0 tready=0",
                     out_valid, out_data, out_keep, out_last, in_tready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({out_valid, out_data, out_keep, out_last, actual_type_ready} !==
            {1'b1, 64'd7, 64'd6, 64'd5, 64'd4, 4'hF, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL w32_sub1: v=%b data=%h keep=%h last=%b type_rdy=%b required v=1 data=7,6,5,4 keep=f last=1 type_rdy=1",
                     out_valid, out_data, out_keep, out_last, actual_type_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL w32_done: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_w8_trailing_drop();
        logic [255:0] d;
        for (int j = 0; j < 32; j++) d[8*j +: 8] = 8'h10 + 8'(j);
        actual_type_data = 8'd8;
        in_tdata = d; in_tkeep = 32'h0000_003F; in_tlast = 1'b1; in_tvalid = 1'b1;
        @(posedge clk); #1;
        in_tvalid = 1'b0;
        @(negedge clk);
        tests++;
        if ({out_valid, out_data, out_keep, out_last} !==
            {1'b1, 64'h13, 64'h12, 64'h11, 64'h10, 4'hF, 1'b0}) begin
            failures++;
            $display("FAIL w8_sub0: v=%b data=%h keep=%h last=%b required v=1 data=13,12,11,10 keep=f last=0",
                     out_valid, out_data, out_keep, out_last);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({out_valid, out_data, out_keep, out_last} !==
            {1'b1, 64'h17, 64'h16, 64'h15, 64'h14, 4'h3, 1'b1}) begin
            failures++;
            $display("FAIL w8_sub1: v=%b data=%h keep=%h last=%b required v=1 data=17,16,15,14 keep=3 last=1",
                     out_valid, out_data, out_keep, out_last);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL w8_dropped: valid=%b required 0 (sub-beats 2..7 dropped)", out_valid);
        end
    endtask

    task automatic test_random_ready();
        logic [255:0] d;
        logic [31:0]  k;
        logic [15:0]  ek;
        int nb, n;
        int hs0 = type_hs;
        int st0 = stab_err;
        int to0 = timeouts;
        int bad = 0;
        actual_type_data = 8'd16;
        exp_q.delete(); got_q.delete();
        collect = 1'b1; rand_ready = 1'b1;
        for (int p = 0; p < 100; p++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                d  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                ek = 16'($urandom);
                if (b == nb - 1) begin
                    case ($urandom_range(0, 3))
                        0: ek = 16'h0000;
                        1: ek = ek & 16'h00FF;
                        2: ek = ek & 16'h000F;
                        default: ;
                    endcase
                end
                k = '0;
                for (int e = 0; e < 16; e++) if (ek[e]) k = k | (32'h3 << (2 * e));
                model_beat(d, k, (b == nb - 1), 16);
                if ($urandom_range(0, 3) == 0) begin in_tvalid = 1'b0; @(posedge clk); #1; end
                send_beat(d, k, (b == nb - 1));
            end
        end
        in_tvalid = 1'b0;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 5000) begin @(posedge clk); n++; end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(posedge clk); #1;
        collect = 1'b0;
        tests++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand_count: got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size() && bad < 10; i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; bad++;
                $display("FAIL rand_beat%0d: got data=%h keep=%h last=%b required data=%h keep=%h last=%b",
                         i, got_q[i].data, got_q[i].keep, got_q[i].last,
                         exp_q[i].data, exp_q[i].keep, exp_q[i].last);
            end
        end
        tests++;
        if (stab_err != st0) begin
            failures++;
            $display("FAIL rand_stable: %0d unstable stalled cycles required 0", stab_err - st0);
        end
        tests++;
        if (type_hs - hs0 != 100) begin
            failures++;
            $display("FAIL rand_type_hs: %0d type handshakes required 100", type_hs - hs0);
        end
        tests++;
        if (timeouts != to0) begin
            failures++;
            $display("FAIL rand_timeout: %0d beats never accepted required 0", timeouts - to0);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [255:0] d;
        for (int j = 0; j < 8; j++) d[32*j +: 32] = 32'd100 + 32'(j);
        actual_type_data = 8'd32;
        in_tdata = d; in_tkeep = '1; in_tlast = 1'b1; in_tvalid = 1'b1;
        @(posedge clk); #1;
        in_tvalid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_last, actual_type_ready} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_now: v/last/type_rdy=%b required 000",
                     {out_valid, out_last, actual_type_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_glitch: valid=%b after release required 0", out_valid);
        end
        for (int j = 0; j < 8; j++) d[32*j +: 32] = 32'd200 + 32'(j);
        @(posedge clk); #1;
        in_tdata = d; in_tvalid = 1'b1;
        @(posedge clk); #1;
        in_tvalid = 1'b0;
        @(negedge clk);
        tests++;
        if ({out_valid, out_data, out_last} !== {1'b1, 64'd203, 64'd202, 64'd201, 64'd200, 1'b0}) begin
            failures++;
            $display("FAIL midreset_fresh0: v=%b data=%h last=%b required v=1 data=203,202,201,200 last=0",
                     out_valid, out_data, out_last);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({out_valid, out_data, out_last} !== {1'b1, 64'd207, 64'd206, 64'd205, 64'd204, 1'b1}) begin
            failures++;
            $display("FAIL midreset_fresh1: v=%b data=%h last=%b required v=1 data=207,206,205,204 last=1",
                     out_valid, out_data, out_last);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [255:0] d [4];
        logic [255:0] e;
        logic tr;
        int cur;
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 8; j++) d[b][32*j +: 32] = 32'(8 * b + j);
        actual_type_data = 8'd32;
        in_tdata = d[0]; in_tkeep = '1; in_tlast = 1'b0; in_tvalid = 1'b1;
        @(posedge clk); #1;
        cur = 1;
        in_tdata = d[1];
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) e[64*i +: 64] = 64'(4 * c + i);
            tests++;
            if ({out_valid, out_data, out_last} !== {1'b1, e, (c == 7)}) begin
                failures++;
                $display("FAIL b2b_cycle%0d: v=%b data=%h last=%b required v=1 data=%h last=%b",
                         c, out_valid, out_data, out_last, e, (c == 7));
            end
            tests++;
            if (in_tready !== (c % 2 == 1)) begin
                failures++;
                $display("FAIL b2b_tready%0d: tready=%b required %b", c, in_tready, (c % 2 == 1));
            end
            tr = in_tready;
            @(posedge clk); #1;
            if (tr && in_tvalid) begin
                cur++;
                if (cur < 4) begin in_tdata = d[cur]; in_tlast = (cur == 3); end
                else in_tvalid = 1'b0;
            end
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done: valid=%b required 0", out_valid);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        in_tvalid = 1'b0; in_tdata = '0; in_tkeep = '0; in_tlast = 1'b0;
        out_ready = 1'b1; actual_type_valid = 1'b0; actual_type_data = 8'd64;
        test_reset();
        test_w64_packet();
        test_w32_split();
        test_w8_trailing_drop();
        test_random_ready();
        test_reset_mid_packet();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
